// File: rtl/alarm_unit.sv
// Alarm comparator, alarm-time register and IDLE/RINGING/SNOOZE ringer FSM.
// Define ALARM_SNOOZE_EN to build the SNOOZE state and snooze countdown.
module alarm_unit #(
    parameter int sec_div        = 100000000,
    parameter int ring_timeout_s = 60,
    parameter int snooze_min     = 5
) (
    input  logic       CLK100MHZ,
    input  logic       RST,
    input  logic [3:0] hr_u,
    input  logic [3:0] hr_l,
    input  logic [3:0] min_u,
    input  logic [3:0] min_l,
    input  logic [5:0] sec,
    input  logic       arm,
    input  logic       inc_h,
    input  logic       inc_m,
    input  logic       dismiss,
    input  logic       snooze,
    output logic [3:0] al_hr_u,
    output logic [3:0] al_hr_l,
    output logic [3:0] al_min_u,
    output logic [3:0] al_min_l,
    output logic       ringing,
    output logic       snoozing,
    output logic       alarm_out
);

    localparam int PW = (sec_div > 1) ? $clog2(sec_div) : 1;
    localparam int RW = (ring_timeout_s > 1) ? $clog2(ring_timeout_s) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(sec_div - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(sec_div / 2);
    localparam logic [RW-1:0] RING_LAST  = RW'(ring_timeout_s - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1
`ifdef ALARM_SNOOZE_EN
        , SNOOZE = 2'd2
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    al_hr_u_q, al_hr_l_q, al_min_u_q, al_min_l_q;
    logic [3:0]    al_hr_u_d, al_hr_l_d, al_min_u_d, al_min_l_d;
    logic          match, match_q, trigger;
    logic [PW-1:0] presc_q, presc_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic          sec_tick, ring_done, stay;
    logic          ringing_q, alarm_out_q;

    // Alarm time editing: hour wraps 23->00, minute wraps 59->00 without carry.
    always_comb begin
        al_hr_u_d  = al_hr_u_q;
        al_hr_l_d  = al_hr_l_q;
        al_min_u_d = al_min_u_q;
        al_min_l_d = al_min_l_q;
        if (inc_h) begin
            if (al_hr_u_q == 4'd2 && al_hr_l_q == 4'd3) begin
                al_hr_u_d = 4'd0;
                al_hr_l_d = 4'd0;
            end else if (al_hr_l_q == 4'd9) begin
                al_hr_u_d = al_hr_u_q + 4'd1;
                al_hr_l_d = 4'd0;
            end else begin
                al_hr_l_d = al_hr_l_q + 4'd1;
            end
        end
        if (inc_m) begin
            if (al_min_l_q == 4'd9) begin
                al_min_l_d = 4'd0;
                al_min_u_d = (al_min_u_q == 4'd5) ? 4'd0 : al_min_u_q + 4'd1;
            end else begin
                al_min_l_d = al_min_l_q + 4'd1;
            end
        end
    end

    assign match = arm && (sec == 6'd0) &&
                   ({hr_u, hr_l, min_u, min_l} == {al_hr_u_q, al_hr_l_q, al_min_u_q, al_min_l_q});
    assign trigger   = match && !match_q;
    assign sec_tick  = (presc_q == PRESC_LAST);
    assign ring_done = sec_tick && (ring_cnt_q == RING_LAST);

`ifdef ALARM_SNOOZE_EN
    localparam int SNOOZE_S = snooze_min * 60;
    localparam int SW = (SNOOZE_S > 1) ? $clog2(SNOOZE_S) : 1;
    localparam logic [SW-1:0] SNZ_LAST = SW'(SNOOZE_S - 1);

    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
    logic          snz_done, snoozing_q;

    assign snz_done = sec_tick && (snz_cnt_q == SNZ_LAST);
    assign snoozing = snoozing_q;
`else
    logic unused_snooze;
    assign unused_snooze = snooze;
    assign snoozing      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (!arm) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!dismiss && trigger) state_d = RINGING;
                RINGING: begin
                    if (dismiss)        state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
                    else if (snooze)    state_d = SNOOZE;
`endif
                    else if (ring_done) state_d = IDLE;
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (dismiss)       state_d = IDLE;
                    else if (snz_done) state_d = RINGING;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // Counters restart on every state entry so second boundaries align to it.
    assign stay = (state_d == state_q);
    always_comb begin
        presc_d    = '0;
        ring_cnt_d = '0;
        if (stay && state_d != IDLE)
            presc_d = sec_tick ? '0 : presc_q + 1'b1;
        if (stay && state_d == RINGING)
            ring_cnt_d = sec_tick ? ring_cnt_q + 1'b1 : ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d = '0;
        if (stay && state_d == SNOOZE)
            snz_cnt_d = sec_tick ? snz_cnt_q + 1'b1 : snz_cnt_q;
`endif
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state_q     <= IDLE;
            al_hr_u_q   <= 4'd0;
            al_hr_l_q   <= 4'd0;
            al_min_u_q  <= 4'd0;
            al_min_l_q  <= 4'd0;
            match_q     <= 1'b0;
            presc_q     <= '0;
            ring_cnt_q  <= '0;
            ringing_q   <= 1'b0;
            alarm_out_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q   <= '0;
            snoozing_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            al_hr_u_q   <= al_hr_u_d;
            al_hr_l_q   <= al_hr_l_d;
            al_min_u_q  <= al_min_u_d;
            al_min_l_q  <= al_min_l_d;
            match_q     <= match;
            presc_q     <= presc_d;
            ring_cnt_q  <= ring_cnt_d;
            ringing_q   <= (state_d == RINGING);
            alarm_out_q <= (state_d == RINGING) && (presc_d < PRESC_HALF);
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q   <= snz_cnt_d;
            snoozing_q  <= (state_d == SNOOZE);
`endif
        end
    end

    assign al_hr_u   = al_hr_u_q;
    assign al_hr_l   = al_hr_l_q;
    assign al_min_u  = al_min_u_q;
    assign al_min_l  = al_min_l_q;
    assign ringing   = ringing_q;
    assign alarm_out = alarm_out_q;

endmodule
